// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store unit between execute and writeback.
// Takes the ALU result as a byte address and checks size/alignment. It then
// drives a word-addressed memory port with byte enables, waits for the
// acknowledge and returns extended load data or a store completion.
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic             r_we;
  logic [2:0]       r_funct3;
  logic [1:0]       r_off;
  logic [3:0]       r_be;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;

  logic             w_accept;
  logic             w_illegal;
  logic             w_misaligned;
  logic             w_ok;
  logic [3:0]       w_be_req;
  logic [WIDTH-1:0] w_wdata_req;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_load_ext;

  assign w_accept = (r_state == IDLE) && req_valid;

  // Decode legality, alignment, lane enables and replicated store data of the incoming request
  always_comb begin
    w_illegal    = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                   (req_funct3[2] && req_we);
    w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_ok         = !w_illegal && !w_misaligned;
    w_be_req     = 4'b1111;
    w_wdata_req  = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be_req    = 4'b0001 << req_addr[1:0];
        w_wdata_req = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be_req    = 4'b0011 << req_addr[1:0];
        w_wdata_req = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be_req    = 4'b1111;
        w_wdata_req = req_wdata;
      end
    endcase
  end

  // Select the addressed lane of the returned word and sign/zero extend it
  always_comb begin
    w_byte     = '0;
    w_half     = '0;
    w_load_ext = '0;
    case (r_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_ext = {{(WIDTH-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {{(WIDTH-8){1'b0}}, w_byte};
      3'b001:  w_load_ext = {{(WIDTH-16){w_half[15]}}, w_half};
      3'b101:  w_load_ext = {{(WIDTH-16){1'b0}}, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: bad requests skip the memory and go straight to the response
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_ok ? REQ : RESP;
      REQ:     if (mem_ack)   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request capture on accept and load data capture on acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_be     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_off    <= req_addr[1:0];
      r_err    <= !w_ok;
      r_rdata  <= '0;
      // Memory-facing registers only move when an access is really made,
      // so mem_addr/mem_wdata keep their last values across error responses.
      // Loads read the whole word, so their enables stay clear.
      if (w_ok) begin
        r_addr  <= {req_addr[WIDTH-1:2], 2'b00};
        r_wdata <= w_wdata_req;
        r_be    <= req_we ? w_be_req : 4'b0000;
      end
    end else if ((r_state == REQ) && mem_ack) begin
      r_rdata <= r_we ? '0 : w_load_ext;
    end
  end

  assign req_ready = (r_state == IDLE);
  assign mem_req   = (r_state == REQ);
  assign mem_we    = mem_req && r_we;
  assign mem_be    = mem_req ? r_be : 4'b0000;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = rsp_valid ? r_rdata : '0;
  assign rsp_err   = rsp_valid && r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed table, multi-cycle reset corner
// and randomized operations against a byte-level memory reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned waits;
    logic        junk;
    logic        spur;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // phys: the memory as written through the DUT port; refm: the spec model
  logic [7:0] phys [int unsigned];
  logic [7:0] refm [int unsigned];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_phys(input int unsigned a);
    if (phys.exists(a)) return phys[a];
    return 8'(a) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] rd_ref(input int unsigned a);
    if (refm.exists(a)) return refm[a];
    return 8'(a) ^ 8'h5A;
  endfunction

  // Reference model: computes the expected result of one operation
  task automatic model(inout vec_t v);
    int unsigned size;
    longint unsigned val;
    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    v.err = (v.f3 == 3'd3) || (v.f3 == 3'd6) || (v.f3 == 3'd7) ||
            ((v.f3 >= 3'd4) && v.we) || ((v.addr % size) != 0);
    v.be = '0; v.wd = '0; v.rdata = '0;
    if (!v.err && v.we) begin
      v.be = 4'(((1 << size) - 1) << (v.addr % 4));
      if (size == 1)      v.wd = (v.wdata & 32'hFF) * 32'h0101_0101;
      else if (size == 2) v.wd = (v.wdata & 32'hFFFF) * 32'h0001_0001;
      else                v.wd = v.wdata;
    end
    if (!v.err && !v.we) begin
      val = 0;
      for (int i = 0; i < int'(size); i++)
        val = val | (longint'(rd_ref(v.addr + i)) << (8 * i));
      if (v.f3 < 3'd4 && size < 4 && val >= (64'd1 << (8 * size - 1)))
        val = val + 64'h1_0000_0000 - (64'd1 << (8 * size));
      v.rdata = val[31:0];
    end
  endtask

  task automatic ref_store(input vec_t v);
    int unsigned size;
    size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    for (int i = 0; i < int'(size); i++) refm[v.addr + i] = 8'(v.wdata >> (8 * i));
  endtask

  // Drive one op from an IDLE negedge, act as memory, check every cycle
  task automatic run_op(input vec_t v);
    logic [31:0] w;
    chk("ready_idle", req_ready, 1);
    if (v.spur) begin
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      chk("idle_spur_ready", req_ready, 1);
      chk("idle_spur_rsp", rsp_valid, 0);
      mem_ack = 1'b0;
    end
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    if (v.junk) begin
      req_valid = 1'b1; req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    if (v.err) begin
      chk("err_mem_req", mem_req, 0);
      chk("err_rsp_valid", rsp_valid, 1);
      chk("err_rsp_err", rsp_err, 1);
      chk("err_rsp_rdata", rsp_rdata, 0);
      chk("err_ready", req_ready, 0);
      req_valid = 1'b0;
      @(negedge clk);
      chk("err_ready_back", req_ready, 1);
      chk("err_rsp_single", rsp_valid, 0);
      chk("err_rsp_err_low", rsp_err, 0);
    end else begin
      for (int unsigned c = 0; c <= v.waits; c++) begin
        chk("req_mem_req", mem_req, 1);
        chk("req_mem_we", mem_we, v.we);
        chk("req_mem_be", mem_be, v.be);
        chk("req_mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
        if (v.we) chk("req_mem_wdata", mem_wdata, v.wd);
        chk("req_rsp_valid", rsp_valid, 0);
        chk("req_ready_busy", req_ready, 0);
        if (c == v.waits) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) phys[mem_addr + i] = mem_wdata[8*i +: 8];
            mem_rdata = $urandom;
          end else begin
            for (int i = 0; i < 4; i++) w[8*i +: 8] = rd_phys(mem_addr + i);
            mem_rdata = w;
          end
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        @(negedge clk);
      end
      req_valid = 1'b0;
      mem_ack = v.spur; mem_rdata = $urandom;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, 0);
      chk("rsp_rdata", rsp_rdata, v.rdata);
      chk("rsp_mem_req", mem_req, 0);
      chk("rsp_mem_be", mem_be, 0);
      chk("rsp_mem_we", mem_we, 0);
      chk("rsp_ready", req_ready, 0);
      @(negedge clk);
      mem_ack = 1'b0;
      chk("post_rsp_single", rsp_valid, 0);
      chk("post_ready", req_ready, 1);
      chk("post_mem_req", mem_req, 0);
      if (v.we) ref_store(v);
    end
  endtask

  vec_t tbl [19];
  vec_t rv;

  initial begin
    tbl[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0,        2, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF80, 4'h0, 32'h0};
    tbl[1]  = '{1'b0, 3'b100, 32'h1003, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 4'h0, 32'h0};
    tbl[2]  = '{1'b1, 3'b001, 32'h2002, 32'h1234ABCD, 0, 1'b0, 1'b0, 1'b0, 32'h0,         4'hC, 32'hABCD_ABCD};
    tbl[3]  = '{1'b0, 3'b010, 32'h3001, 32'h0,        0, 1'b0, 1'b0, 1'b1, 32'h0,         4'h0, 32'h0};
    tbl[4]  = '{1'b1, 3'b101, 32'h2000, 32'h5,        0, 1'b0, 1'b0, 1'b1, 32'h0,         4'h0, 32'h0};
    tbl[5]  = '{1'b1, 3'b010, 32'h4000, 32'hDEADBEEF, 1, 1'b1, 1'b0, 1'b0, 32'h0,         4'hF, 32'hDEAD_BEEF};
    tbl[6]  = '{1'b0, 3'b010, 32'h4000, 32'h0,        0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'h0, 32'h0};
    tbl[7]  = '{1'b0, 3'b001, 32'h1002, 32'h0,        1, 1'b0, 1'b0, 1'b0, 32'hFFFF_80AA, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 3'b101, 32'h1002, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h0000_80AA, 4'h0, 32'h0};
    tbl[9]  = '{1'b0, 3'b000, 32'h1001, 32'h0,        0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFBB, 4'h0, 32'h0};
    tbl[10] = '{1'b1, 3'b000, 32'h1000, 32'h1234567E, 3, 1'b1, 1'b0, 1'b0, 32'h0,         4'h1, 32'h7E7E_7E7E};
    tbl[11] = '{1'b0, 3'b000, 32'h1000, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h0000_007E, 4'h0, 32'h0};
    tbl[12] = '{1'b0, 3'b011, 32'h1000, 32'h0,        0, 1'b0, 1'b0, 1'b1, 32'h0,         4'h0, 32'h0};
    tbl[13] = '{1'b0, 3'b001, 32'h1001, 32'h0,        0, 1'b0, 1'b0, 1'b1, 32'h0,         4'h0, 32'h0};
    tbl[14] = '{1'b0, 3'b010, 32'h1000, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h80AA_BB7E, 4'h0, 32'h0};
    tbl[15] = '{1'b1, 3'b000, 32'h1003, 32'h55,       0, 1'b0, 1'b0, 1'b0, 32'h0,         4'h8, 32'h5555_5555};
    tbl[16] = '{1'b0, 3'b010, 32'h2000, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'hABCD_5B5A, 4'h0, 32'h0};
    tbl[17] = '{1'b1, 3'b110, 32'h1000, 32'h0,        0, 1'b0, 1'b0, 1'b1, 32'h0,         4'h0, 32'h0};
    tbl[18] = '{1'b1, 3'b100, 32'h1000, 32'h0,        0, 1'b0, 1'b0, 1'b1, 32'h0,         4'h0, 32'h0};

    phys[32'h1000] = 8'hCC; phys[32'h1001] = 8'hBB; phys[32'h1002] = 8'hAA; phys[32'h1003] = 8'h80;
    refm[32'h1000] = 8'hCC; refm[32'h1001] = 8'hBB; refm[32'h1002] = 8'hAA; refm[32'h1003] = 8'h80;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", req_ready, 1);

    for (int i = 0; i < 19; i++) run_op(tbl[i]);

    // Async reset while waiting for the acknowledge discards the op
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midreq_mem_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreq_drop", mem_req, 0);
    chk("midreq_ready", req_ready, 1);
    @(negedge clk);
    mem_ack = 1'b1;
    chk("midreq_no_rsp0", rsp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreq_no_rsp1", rsp_valid, 0);
    chk("midreq_no_req", mem_req, 0);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("midreq_no_rsp2", rsp_valid, 0);

    for (int n = 0; n < 300; n++) begin
      rv.we    = 1'($urandom);
      rv.f3    = 3'($urandom);
      rv.addr  = 32'h5000 + ($urandom % 64);
      rv.wdata = $urandom;
      rv.waits = $urandom % 4;
      rv.junk  = 1'($urandom);
      rv.spur  = 1'($urandom);
      model(rv);
      run_op(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the ALU in the execute/memory path. It takes the ALU result as the effective byte address for a load or store, checks alignment, and drives a word-addressed data-memory port with byte enables. It waits for the memory acknowledge, then returns sign- or zero-extended load data, or a completion for stores, to the writeback stage.

## Interface
- WIDTH, 32: data/address width; only 32 is supported.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  memory op presented by execute stage
- req_ready  out  1  high when unit can accept (state IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  WIDTH  effective byte address (ALU output)
- req_wdata  in  WIDTH  store data (rs2), size-aligned in low bits
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  WIDTH  word address, bits [1:0] always 00
- mem_be  out  4  byte enables (lane i = bits 8i+7:8i)
- mem_wdata  out  WIDTH  lane-replicated store data
- mem_rdata  in  WIDTH  read word, valid when mem_ack=1
- mem_ack  in  1  memory completion, sampled only in REQ
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  WIDTH  extended load data; 0 for stores/errors
- rsp_err  out  1  misaligned or illegal op; valid with rsp_valid

## Operation
- FSM states: IDLE, REQ, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid=1, latch we, funct3, addr[1:0], wdata.
  - If the request is legal and aligned, go to REQ.
  - Otherwise go to RESP with rsp_err=1; no memory access is made.
- REQ: mem_req=1. All mem_* outputs are stable for the whole state. On mem_ack=1, capture mem_rdata and go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- Illegal ops: funct3 011/110/111 (any op); 100/101 with req_we=1.
- Misaligned ops: H/HU with addr[0]=1; W with addr[1:0]≠00.
- Byte enables:
  - B: 0001<<addr[1:0]
  - H: 0011<<addr[1:0]
  - W: 1111
- mem_wdata:
  - B: {4{wdata[7:0]}}
  - H: {2{wdata[15:0]}}
  - W: wdata
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- rsp_rdata = 0 for stores and on error. rsp_err = 0 whenever rsp_valid = 0.
- Outside REQ: mem_req, mem_we, mem_be = 0. mem_addr and mem_wdata hold their last values.
- mem_ack outside REQ is ignored.
- req_valid while busy is ignored; the upstream stage holds or stalls.

## Timing
- Reset (async, rst_n=0): state=IDLE. req_ready=1. mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err all 0.
- Accept at edge E0:
  - mem_req is high from cycle E0+1.
  - If mem_ack is seen at edge Ek, rsp_valid is high in cycle Ek+1 and req_ready returns in cycle Ek+2.
  - Minimum (ack in first REQ cycle): 3 cycles from accept to next accept.
- Error path: accept at E0, rsp_valid+rsp_err in cycle E0+1, req_ready in cycle E0+2. mem_req never asserts.
- Wait states: mem_ack may be delayed indefinitely; there is no timeout.
- Reset mid-REQ: mem_req drops immediately (async). The pending op is discarded and no rsp_valid follows.
- All outputs are registered or decoded from state only. No combinational path from req_* or mem_ack to outputs.

## Test plan
- Reset → req_ready=1, mem_req=0, rsp_valid=0. Assert rst_n=0 during REQ → mem_req falls without a clock, no rsp_valid.
- LB at addr 0x1003, mem_rdata=0x80AABBCC, ack after 2 wait cycles:
  - mem_addr=0x1000, mem_be=0000 (read), mem_we=0.
  - rsp_rdata=0xFFFFFF80, rsp_valid exactly one cycle.
  - Repeat as LBU → 0x00000080.
- SH at addr 0x2002, wdata=0x1234ABCD, same-cycle ack → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x2000, rsp_rdata=0, rsp_err=0.
- LW at addr 0x3001 → no mem_req; rsp_valid+rsp_err=1 in cycle after accept, rsp_rdata=0. SHU (funct3=101, we=1) → rsp_err=1.
- Back-to-back: SW 0x4000 data 0xDEADBEEF, then LW 0x4000 with memory model returning stored word:
  - req_valid asserted during busy is ignored; the second op is accepted on the req_ready=1 cycle.
  - Load returns 0xDEADBEEF.
- Spurious mem_ack=1 in IDLE and RESP → no state change, no extra rsp_valid.
